// File: rtl/hazard_detection.sv
// Decode-stage hazard unit for the 5-stage RV32I pipeline.
// Detects load-use hazards against ID/EX and inserts a single bubble.
// Squashes wrong-path instructions when EX redirects the PC.
// Holds every stage while the external freeze is asserted.
// A small RUN/STALL/FLUSH FSM tracks these events and drives the event counters.
//
// Handshake: there is no valid/ready pair. Each enable/flush output is a
// same-cycle command to the pipeline registers. freeze dominates all other
// conditions and suppresses every state and counter update on that edge.
module hazard_detection #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_id,
    input  logic [4:0]           rs1_id,
    input  logic [4:0]           rs2_id,
    input  logic                 use_rs1_id,
    input  logic                 use_rs2_id,
    input  logic [4:0]           rd_idex,
    input  logic                 mem_read_idex,
    input  logic                 branch_taken_ex,
    input  logic                 freeze,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_write,
    output logic                 idex_flush,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic                 hazard_error
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 err_q, err_d;
    logic                 lu_hazard;
    logic                 rs1_match;
    logic                 rs2_match;

    // Load-use detection: a load to x0 never creates a dependency.
    always_comb begin
        rs1_match = use_rs1_id && (rs1_id == rd_idex);
        rs2_match = use_rs2_id && (rs2_id == rd_idex);
        lu_hazard = valid_id && mem_read_idex && (rd_idex != 5'd0)
                    && (rs1_match || rs2_match);
    end

    // State, counter and sticky error registers; asynchronous reset back to RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    // Next-state and counter updates; everything holds while frozen.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;
        if (!freeze) begin
            if (branch_taken_ex) begin
                // The redirect wins in every state because ID holds a wrong-path instruction.
                state_d     = ST_FLUSH;
                flush_cnt_d = flush_cnt_q + 1'b1;
            end else if (lu_hazard) begin
                state_d     = ST_STALL;
                stall_cnt_d = stall_cnt_q + 1'b1;
                // In STALL, ID/EX holds a bubble, so a second detection points to an upstream bug.
                if (state_q == ST_STALL) begin
                    err_d = 1'b1;
                end
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // Pipeline control outputs; same-cycle priority freeze > redirect > load-use.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_write = 1'b1;
        idex_flush = 1'b0;
        if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Register-backed status outputs.
    always_comb begin
        state        = state_q;
        stall_count  = stall_cnt_q;
        flush_count  = flush_cnt_q;
        hazard_error = err_q;
    end

endmodule

// File: tb/tb_hazard_detection.sv
// Directed bench for hazard_detection.
// Control outputs are packed as {pc_write, ifid_write, ifid_flush, idex_write, idex_flush}.
module tb_hazard_detection;

    localparam logic [4:0] CTL_RUN    = 5'b11010;
    localparam logic [4:0] CTL_BRANCH = 5'b11111;
    localparam logic [4:0] CTL_LU     = 5'b00011;
    localparam logic [4:0] CTL_FREEZE = 5'b00000;

    logic        clk;
    logic        reset;
    logic        valid_id;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        use_rs1_id;
    logic        use_rs2_id;
    logic [4:0]  rd_idex;
    logic        mem_read_idex;
    logic        branch_taken_ex;
    logic        freeze;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_flush;
    logic [1:0]  state;
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    logic        hazard_error;
    logic [4:0]  ctl;

    int total = 0;
    int bad   = 0;

    hazard_detection #(.CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_idex(rd_idex),
        .mem_read_idex(mem_read_idex), .branch_taken_ex(branch_taken_ex), .freeze(freeze),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .state(state),
        .stall_count(stall_count), .flush_count(flush_count), .hazard_error(hazard_error)
    );

    assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        valid_id = 1'b0; rs1_id = 5'd0; rs2_id = 5'd0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
        rd_idex = 5'd0; mem_read_idex = 1'b0; branch_taken_ex = 1'b0; freeze = 1'b0;
    endtask

    // Sets up a load to x5 in ID/EX while ID reads x5 through rs1.
    task automatic set_lu();
        valid_id = 1'b1; rs1_id = 5'd5; use_rs1_id = 1'b1; rs2_id = 5'd0; use_rs2_id = 1'b0;
        rd_idex = 5'd5; mem_read_idex = 1'b1;
    endtask

    // Advances one clock edge and settles 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        total++;
        if (state !== 2'b00 || stall_count !== 32'd0 || flush_count !== 32'd0 || hazard_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs: got state=%b stall=%0d flush=%0d err=%b, expected 00/0/0/0",
                     state, stall_count, flush_count, hazard_error);
        end
        total++;
        if (ctl !== CTL_RUN) begin
            bad++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RUN);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu();
        #1;
        total++;
        if (ctl !== CTL_LU) begin bad++; $display("FAIL lu_ctl: got %b expected %b", ctl, CTL_LU); end
        tick();
        total++;
        if (state !== 2'b01 || stall_count !== 32'd1) begin
            bad++; $display("FAIL lu_stall: got state=%b stall=%0d expected 01/1", state, stall_count);
        end
        // A bubble now occupies ID/EX.
        mem_read_idex = 1'b0; rd_idex = 5'd0;
        #1;
        total++;
        if (ctl !== CTL_RUN) begin bad++; $display("FAIL lu_release_ctl: got %b expected %b", ctl, CTL_RUN); end
        tick();
        total++;
        if (state !== 2'b00 || stall_count !== 32'd1 || hazard_error !== 1'b0) begin
            bad++; $display("FAIL lu_back_run: got state=%b stall=%0d err=%b expected 00/1/0",
                            state, stall_count, hazard_error);
        end
        // The rs2 path detects a hazard in the same way.
        valid_id = 1'b1; use_rs1_id = 1'b0; use_rs2_id = 1'b1; rs2_id = 5'd17;
        rd_idex = 5'd17; mem_read_idex = 1'b1;
        #1;
        total++;
        if (ctl !== CTL_LU) begin bad++; $display("FAIL lu_rs2_ctl: got %b expected %b", ctl, CTL_LU); end
        tick();
        total++;
        if (state !== 2'b01 || stall_count !== 32'd2) begin
            bad++; $display("FAIL lu_rs2_stall: got state=%b stall=%0d expected 01/2", state, stall_count);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_no_hazard();
        do_reset();
        // Cases: load to x0; rs1 unused; ID is a bubble; ID/EX is not a load.
        for (int k = 0; k < 4; k++) begin
            set_lu();
            case (k)
                0: begin rd_idex = 5'd0; rs1_id = 5'd0; end
                1: use_rs1_id = 1'b0;
                2: valid_id = 1'b0;
                default: mem_read_idex = 1'b0;
            endcase
            #1;
            total++;
            if (ctl !== CTL_RUN) begin bad++; $display("FAIL nohaz_ctl[%0d]: got %b expected %b", k, ctl, CTL_RUN); end
            tick();
            total++;
            if (state !== 2'b00 || stall_count !== 32'd0) begin
                bad++; $display("FAIL nohaz_state[%0d]: got state=%b stall=%0d expected 00/0", k, state, stall_count);
            end
        end
        idle_inputs();
    endtask

    task automatic test_branch_override();
        do_reset();
        set_lu();
        branch_taken_ex = 1'b1;
        #1;
        total++;
        if (ctl !== CTL_BRANCH) begin bad++; $display("FAIL br_ctl: got %b expected %b", ctl, CTL_BRANCH); end
        tick();
        total++;
        if (state !== 2'b10 || flush_count !== 32'd1 || stall_count !== 32'd0) begin
            bad++; $display("FAIL br_flush: got state=%b flush=%0d stall=%0d expected 10/1/0",
                            state, flush_count, stall_count);
        end
        // A branch immediately after a flush is handled the same way.
        idle_inputs();
        branch_taken_ex = 1'b1;
        tick();
        total++;
        if (state !== 2'b10 || flush_count !== 32'd2) begin
            bad++; $display("FAIL br_again: got state=%b flush=%0d expected 10/2", state, flush_count);
        end
        idle_inputs();
        tick();
        total++;
        if (state !== 2'b00 || flush_count !== 32'd2) begin
            bad++; $display("FAIL br_back_run: got state=%b flush=%0d expected 00/2", state, flush_count);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        set_lu();
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            // The third frozen cycle also presents a redirect, which must be ignored.
            if (c == 2) branch_taken_ex = 1'b1;
            #1;
            total++;
            if (ctl !== CTL_FREEZE) begin bad++; $display("FAIL frz_ctl[%0d]: got %b expected %b", c, ctl, CTL_FREEZE); end
            tick();
            total++;
            if (state !== 2'b00 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
                bad++; $display("FAIL frz_hold[%0d]: got state=%b stall=%0d flush=%0d expected 00/0/0",
                                c, state, stall_count, flush_count);
            end
        end
        branch_taken_ex = 1'b0;
        freeze = 1'b0;
        #1;
        total++;
        if (ctl !== CTL_LU) begin bad++; $display("FAIL frz_release_ctl: got %b expected %b", ctl, CTL_LU); end
        tick();
        total++;
        if (state !== 2'b01 || stall_count !== 32'd1) begin
            bad++; $display("FAIL frz_release: got state=%b stall=%0d expected 01/1", state, stall_count);
        end
        // A freeze while in STALL keeps the state in STALL.
        idle_inputs();
        freeze = 1'b1;
        tick();
        total++;
        if (state !== 2'b01) begin bad++; $display("FAIL frz_in_stall: got state=%b expected 01", state); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_lu();
        tick();
        #1;
        total++;
        if (ctl !== CTL_LU) begin bad++; $display("FAIL b2b_ctl: got %b expected %b", ctl, CTL_LU); end
        tick();
        total++;
        if (state !== 2'b01 || stall_count !== 32'd2 || hazard_error !== 1'b1) begin
            bad++; $display("FAIL b2b_err: got state=%b stall=%0d err=%b expected 01/2/1",
                            state, stall_count, hazard_error);
        end
        idle_inputs();
        tick();
        tick();
        total++;
        if (state !== 2'b00 || hazard_error !== 1'b1) begin
            bad++; $display("FAIL b2b_sticky: got state=%b err=%b expected 00/1", state, hazard_error);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        // Two back-to-back detections: stall=2, error set.
        set_lu();
        tick();
        tick();
        idle_inputs();
        tick();
        // Four single stalls bring the count to 6.
        for (int n = 0; n < 4; n++) begin
            set_lu();
            tick();
            idle_inputs();
            tick();
        end
        set_lu();
        tick();
        total++;
        if (state !== 2'b01 || stall_count !== 32'd7 || hazard_error !== 1'b1) begin
            bad++; $display("FAIL arst_setup: got state=%b stall=%0d err=%b expected 01/7/1",
                            state, stall_count, hazard_error);
        end
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (state !== 2'b00 || stall_count !== 32'd0 || flush_count !== 32'd0 || hazard_error !== 1'b0) begin
            bad++; $display("FAIL arst_clear: got state=%b stall=%0d flush=%0d err=%b expected 00/0/0/0",
                            state, stall_count, flush_count, hazard_error);
        end
        #1;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_override();
        test_freeze();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
